rs_age_select: RTL and testbench
================================

Name:
rs_age_select

Overview:
Parametrised successor reservation station for the Tomasulo back end, sitting between dispatch and one functional-unit group.
- Holds up to NUM_ENTRIES instructions, with no shifting.
- Captures operands from NUM_WAKEUP broadcast channels, including wakeups that arrive in the same cycle as dispatch.
- Issues the oldest ready entry to the FU over a valid/ready handshake.
- Supports a full flush on mispredict.

Parameters:
NUM_ENTRIES, 8, number of RS slots; must be a power of two and at least 2
NUM_WAKEUP, 4, number of CDB/FU wakeup channels
IDX_W, $clog2(NUM_ENTRIES), slot index width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dispatch_valid  in  1  dispatch presents an instruction
dispatch_insn  in  INST_RS  instruction with tag_src1/2, ready_src1/2, value_src1/2, insn_tag
dispatch_ready  out  1  RS can accept; equals !is_full
wakeup  in  NUM_WAKEUP  per-channel broadcast valid
wakeup_tag  in  NUM_WAKEUP x ROB_TAG_LEN  producing ROB tag
wakeup_value  in  NUM_WAKEUP x XLEN  produced value
issue_valid  out  1  issue_insn holds a ready instruction
issue_insn  out  RS_ENTRY  oldest ready entry
issue_ready  in  1  FU accepts issue_insn this cycle
flush  in  1  invalidate all entries
is_full  out  1  all slots valid
free_count  out  IDX_W+1  number of invalid slots

Behaviour:
- Reset (synchronous, clk edge with reset=1) clears all valid bits and the age matrix. After reset: issue_valid=0, issue_insn=0, is_full=0, dispatch_ready=1, free_count=NUM_ENTRIES.
- Outputs are derived combinationally from registered state. dispatch_ready, is_full and free_count depend only on current state, so there is no path from issue_ready or dispatch_valid to dispatch_ready.
- Allocation: on dispatch_valid && dispatch_ready, the lowest-index invalid slot is written at the edge. Its age row marks it younger than every currently valid entry.
- Dispatch bypass: for each source with ready_srcX=0, a matching wakeup in the same cycle sets ready_srcX=1 and captures the value on write.
- Wakeup capture: a source updates only while its ready_srcX=0; an already-ready source is never overwritten. If several channels match, the lowest channel index wins.
- A wakeup at edge t makes an entry eligible from cycle t+1. There is no same-cycle wakeup-to-issue path.
- A newly dispatched entry is eligible one cycle after its write edge at the earliest.
- Select: among entries with valid && ready_src1 && ready_src2, pick the one that no other eligible entry is older than. issue_valid=1 when at least one entry is eligible.
- Issue: on issue_valid && issue_ready, the selected slot's valid bit clears at the edge.
- issue_insn is held stable while issue_valid=1 && issue_ready=0, unless a strictly older entry becomes eligible; FU must tolerate that.
- Issue and dispatch in the same cycle are both performed. A slot freed by issue is reusable at the following edge, not in the same edge.
- flush: all valid bits clear at the edge. Flush has priority over same-cycle dispatch (dropped) and issue (handshake ignored). Outputs equal reset values in the next cycle.
- reset has priority over flush.
- Age matrix: age[i][j]=1 means i is older than j.
  - On allocate into slot k: set age[x][k]=1 for each valid x, and clear age[k][*].
  - Entries freed need no age cleanup; select masks by valid.
- free_count = NUM_ENTRIES minus popcount(valid); width IDX_W+1 so the value NUM_ENTRIES is representable.

Decomposition:
- Shared package (sys_defs.svh): INST_RS, RS_ENTRY, ROB_TAG_LEN, XLEN, and a WAKEUP_BUS struct bundling valid/tag/value per channel.
- Sub-module rs_age_matrix (parametrised NUM_ENTRIES): input allocate one-hot, valid vector, eligible vector; output one-hot oldest-eligible grant.
- Free-slot priority encoder and wakeup CAM stay in the top module.

Test Plan:
- Reset, then 8 dispatches with all sources ready (tags 1..8) and issue_ready=1 -> issue order tags 1..8 on consecutive cycles; is_full never asserted.
- 8 dispatches with src1 pending on tag 20 and issue_ready=0 -> is_full=1, dispatch_ready=0, free_count=0. Then wakeup ch2 tag 20 value 0xABCD -> next cycle issue_valid=1 with insn_tag 1 and value_src1=0xABCD.
- Dispatch tag 5 waiting on tag 9 while wakeup ch0 tag 9 value 7 fires in the same cycle -> entry stored ready; issue_valid=1 one cycle later with value_src1=7.
- Dispatch A (waits on tag 30), then B (ready), then wakeup tag 30 -> B issues first; A issues after its wakeup and is preferred over any younger ready entry.
- Full RS, issue_ready=1 and dispatch_valid=1 in the same cycle -> issue completes, dispatch is not accepted (dispatch_ready=0). Next cycle free_count=1 and dispatch succeeds.
- flush asserted with 5 valid entries and a concurrent dispatch -> next cycle free_count=8, issue_valid=0, and the dispatched instruction is absent.

Source files
------------

// File: rtl/rs_age_select_pkg.sv
// Shared types for the age-ordered reservation station: instruction/entry
// layouts and the per-channel wakeup bundle.
package rs_age_select_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 6;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] insn_tag;
    logic [ROB_TAG_LEN-1:0] tag_src1;
    logic [ROB_TAG_LEN-1:0] tag_src2;
    logic                   ready_src1;
    logic                   ready_src2;
    logic [XLEN-1:0]        value_src1;
    logic [XLEN-1:0]        value_src2;
  } INST_RS;

  // A stored entry carries exactly the dispatched fields, with sources filled in over time.
  typedef INST_RS RS_ENTRY;

  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] tag;
    logic [XLEN-1:0]        value;
  } WAKEUP_BUS;

endpackage

// File: rtl/rs_age_select_age_matrix.sv
// Age matrix for the reservation station: age[i][j]=1 means slot i is older
// than slot j; produces a one-hot grant for the oldest eligible slot.
module rs_age_matrix #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] i_alloc_oh,
  input  logic [NUM_ENTRIES-1:0] i_valid,
  input  logic [NUM_ENTRIES-1:0] i_eligible,
  output logic [NUM_ENTRIES-1:0] o_grant
);

  logic [NUM_ENTRIES-1:0] r_age [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_blocked;

  // Stale bits of freed slots are harmless: select only looks at eligible slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_ENTRIES; r++) r_age[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (i_alloc_oh[k]) begin
          r_age[k] <= '0;
          for (int x = 0; x < NUM_ENTRIES; x++) begin
            if (x != k && i_valid[x]) r_age[x][k] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && i_eligible[j] && r_age[j][i]) w_blocked[i] = 1'b1;
      end
    end
  end

  assign o_grant = i_eligible & ~w_blocked;

endmodule

// File: rtl/rs_age_select.sv
// Non-shifting reservation station: captures operands from wakeup broadcasts
// (including same-cycle dispatch bypass) and issues the oldest ready entry.
module rs_age_select
  import rs_age_select_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  parameter  int NUM_WAKEUP  = 4,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  dispatch_valid,
  input  INST_RS                                dispatch_insn,
  output logic                                  dispatch_ready,
  input  logic [NUM_WAKEUP-1:0]                 wakeup,
  input  logic [NUM_WAKEUP-1:0][ROB_TAG_LEN-1:0] wakeup_tag,
  input  logic [NUM_WAKEUP-1:0][XLEN-1:0]       wakeup_value,
  output logic                                  issue_valid,
  output RS_ENTRY                               issue_insn,
  input  logic                                  issue_ready,
  input  logic                                  flush,
  output logic                                  is_full,
  output logic [IDX_W:0]                        free_count
);

  logic [NUM_ENTRIES-1:0]          r_valid;
  RS_ENTRY                         r_entry [NUM_ENTRIES];
  RS_ENTRY                         w_entry_next [NUM_ENTRIES];
  RS_ENTRY                         w_disp_woken;
  WAKEUP_BUS [NUM_WAKEUP-1:0]      w_wk;
  logic [NUM_ENTRIES-1:0]          w_eligible;
  logic [NUM_ENTRIES-1:0]          w_grant;
  logic [NUM_ENTRIES-1:0]          w_free_oh;
  logic [NUM_ENTRIES-1:0]          w_alloc_oh;
  logic [NUM_ENTRIES-1:0]          w_issue_oh;
  logic [IDX_W:0]                  w_valid_cnt;
  logic                            w_accept;
  logic                            w_fire;

  // Fill any still-pending source from the lowest matching channel; ready sources stay untouched.
  function automatic RS_ENTRY wake_entry(input RS_ENTRY e, input WAKEUP_BUS [NUM_WAKEUP-1:0] wk);
    RS_ENTRY res;
    logic    hit1;
    logic    hit2;
    res  = e;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int c = 0; c < NUM_WAKEUP; c++) begin
      if (!hit1 && !e.ready_src1 && wk[c].valid && wk[c].tag == e.tag_src1) begin
        res.ready_src1 = 1'b1;
        res.value_src1 = wk[c].value;
        hit1           = 1'b1;
      end
      if (!hit2 && !e.ready_src2 && wk[c].valid && wk[c].tag == e.tag_src2) begin
        res.ready_src2 = 1'b1;
        res.value_src2 = wk[c].value;
        hit2           = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    w_wk = '0;
    for (int c = 0; c < NUM_WAKEUP; c++) begin
      w_wk[c].valid = wakeup[c];
      w_wk[c].tag   = wakeup_tag[c];
      w_wk[c].value = wakeup_value[c];
    end
  end

  always_comb begin
    w_disp_woken = wake_entry(dispatch_insn, w_wk);
    for (int i = 0; i < NUM_ENTRIES; i++) w_entry_next[i] = wake_entry(r_entry[i], w_wk);
  end

  always_comb begin
    w_free_oh = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_valid_cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) w_valid_cnt = w_valid_cnt + (IDX_W+1)'(r_valid[i]);
  end

  assign is_full        = &r_valid;
  assign dispatch_ready = !is_full;
  assign free_count     = (IDX_W+1)'(NUM_ENTRIES) - w_valid_cnt;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      w_eligible[i] = r_valid[i] && r_entry[i].ready_src1 && r_entry[i].ready_src2;
  end

  rs_age_matrix #(.NUM_ENTRIES(NUM_ENTRIES)) u_age (
    .clk        (clk),
    .reset      (reset),
    .i_alloc_oh (w_alloc_oh),
    .i_valid    (r_valid),
    .i_eligible (w_eligible),
    .o_grant    (w_grant)
  );

  assign issue_valid = |w_eligible;

  always_comb begin
    issue_insn = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_grant[i]) issue_insn = r_entry[i];
    end
  end

  // Flush drops both the dispatch and the issue handshake of its cycle.
  assign w_accept   = dispatch_valid && dispatch_ready && !flush;
  assign w_fire     = issue_valid && issue_ready && !flush;
  assign w_alloc_oh = w_free_oh & {NUM_ENTRIES{w_accept}};
  assign w_issue_oh = w_grant & {NUM_ENTRIES{w_fire}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~w_issue_oh) | w_alloc_oh;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++)
      r_entry[i] <= w_alloc_oh[i] ? w_disp_woken : w_entry_next[i];
  end

endmodule

// File: tb/tb_rs_age_select.sv
// Directed scoreboard bench for rs_age_select: expected issues are queued at
// stimulus time and compared as the DUT hands them to the FU.
module tb_rs_age_select;
  import rs_age_select_pkg::*;

  localparam int N  = 8;
  localparam int NW = 4;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          dispatch_valid;
  INST_RS                        dispatch_insn;
  logic                          dispatch_ready;
  logic [NW-1:0]                 wakeup;
  logic [NW-1:0][ROB_TAG_LEN-1:0] wakeup_tag;
  logic [NW-1:0][XLEN-1:0]       wakeup_value;
  logic                          issue_valid;
  RS_ENTRY                       issue_insn;
  logic                          issue_ready;
  logic                          flush;
  logic                          is_full;
  logic [3:0]                    free_count;

  typedef struct {
    logic [ROB_TAG_LEN-1:0] tag;
    logic [XLEN-1:0]        v1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic saw_full;

  always #5 clk = ~clk;

  rs_age_select #(.NUM_ENTRIES(N), .NUM_WAKEUP(NW)) dut (
    .clk            (clk),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .dispatch_insn  (dispatch_insn),
    .dispatch_ready (dispatch_ready),
    .wakeup         (wakeup),
    .wakeup_tag     (wakeup_tag),
    .wakeup_value   (wakeup_value),
    .issue_valid    (issue_valid),
    .issue_insn     (issue_insn),
    .issue_ready    (issue_ready),
    .flush          (flush),
    .is_full        (is_full),
    .free_count     (free_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Compare any handshake in the current cycle against the scoreboard, then advance one edge.
  task automatic tick();
    exp_t e;
    #1;
    if (issue_valid && issue_ready && !flush) begin
      if (q.size() == 0) begin
        check("sb_unexpected_issue", 64'(issue_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check("sb_issue_tag", 64'(issue_insn.insn_tag), 64'(e.tag));
        check("sb_issue_v1", 64'(issue_insn.value_src1), 64'(e.v1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int tag, input int t1, input logic r1, input logic [XLEN-1:0] v1);
    dispatch_valid           = 1'b1;
    dispatch_insn.insn_tag   = ROB_TAG_LEN'(tag);
    dispatch_insn.tag_src1   = ROB_TAG_LEN'(t1);
    dispatch_insn.tag_src2   = '0;
    dispatch_insn.ready_src1 = r1;
    dispatch_insn.ready_src2 = 1'b1;
    dispatch_insn.value_src1 = v1;
    dispatch_insn.value_src2 = '0;
  endtask

  task automatic drain(input int budget);
    issue_ready = 1'b1;
    for (int i = 0; i < budget && q.size() > 0; i++) tick();
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_insn = '0;
    issue_ready = 1'b0; wakeup = '0; wakeup_tag = '0; wakeup_value = '0;
    saw_full = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    reset = 1'b0;
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_insn", 64'(|issue_insn), 64'd0);
    check("rst_is_full", 64'(is_full), 64'd0);
    check("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
    check("rst_free_count", 64'(free_count), 64'd8);

    // Streaming: all-ready dispatches issue back-to-back in order
    issue_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      disp(i, 0, 1'b1, XLEN'(32'h100 + i));
      q.push_back('{tag: ROB_TAG_LEN'(i), v1: XLEN'(32'h100 + i)});
      #1;
      if (is_full) saw_full = 1'b1;
      if (i > 1) check("t1_consecutive", 64'(issue_valid), 64'd1);
      tick();
    end
    dispatch_valid = 1'b0;
    drain(10);
    check("t1_never_full", 64'(saw_full), 64'd0);

    // Fill with entries pending on tag 20, then release them by one wakeup
    issue_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      disp(i, 20, 1'b0, 32'hDEAD);
      q.push_back('{tag: ROB_TAG_LEN'(i), v1: 32'hABCD});
      tick();
    end
    dispatch_valid = 1'b0;
    check("t2_is_full", 64'(is_full), 64'd1);
    check("t2_dispatch_ready", 64'(dispatch_ready), 64'd0);
    check("t2_free_count", 64'(free_count), 64'd0);
    check("t2_not_eligible", 64'(issue_valid), 64'd0);
    wakeup = 4'b0100; wakeup_tag[2] = 6'd20; wakeup_value[2] = 32'hABCD;
    #1;
    check("t2_no_same_cycle_issue", 64'(issue_valid), 64'd0);
    tick();
    wakeup = '0;
    check("t2_issue_valid", 64'(issue_valid), 64'd1);
    check("t2_issue_tag", 64'(issue_insn.insn_tag), 64'd1);
    check("t2_issue_v1", 64'(issue_insn.value_src1), 64'hABCD);
    tick();
    check("t2_hold_stable", 64'(issue_insn.insn_tag), 64'd1);

    // Full RS: issue and dispatch together, dispatch must wait a cycle
    issue_ready = 1'b1;
    disp(9, 0, 1'b1, 32'h99);
    #1;
    check("t5_full_not_ready", 64'(dispatch_ready), 64'd0);
    tick();
    issue_ready = 1'b0;
    check("t5_free_count_1", 64'(free_count), 64'd1);
    check("t5_ready_after", 64'(dispatch_ready), 64'd1);
    q.push_back('{tag: 6'd9, v1: 32'h99});
    tick();
    dispatch_valid = 1'b0;
    check("t5_refilled", 64'(free_count), 64'd0);
    drain(20);

    // Dispatch bypass; two channels hit, the lower index supplies the value
    issue_ready = 1'b0;
    disp(5, 9, 1'b0, 32'hBAD);
    wakeup = 4'b0011;
    wakeup_tag[0] = 6'd9; wakeup_value[0] = 32'd7;
    wakeup_tag[1] = 6'd9; wakeup_value[1] = 32'h55;
    q.push_back('{tag: 6'd5, v1: 32'd7});
    tick();
    dispatch_valid = 1'b0; wakeup = '0;
    check("t3_bypass_valid", 64'(issue_valid), 64'd1);
    check("t3_bypass_tag", 64'(issue_insn.insn_tag), 64'd5);
    check("t3_bypass_v1", 64'(issue_insn.value_src1), 64'd7);
    drain(5);

    // Older waiting entry beats a younger ready one once woken
    issue_ready = 1'b0;
    disp(10, 30, 1'b0, 32'h0);
    tick();
    disp(11, 30, 1'b1, 32'hB1);
    q.push_back('{tag: 6'd11, v1: 32'hB1});
    tick();
    dispatch_valid = 1'b0;
    check("t4_ready_first", 64'(issue_insn.insn_tag), 64'd11);
    wakeup = 4'b1000; wakeup_tag[3] = 6'd30; wakeup_value[3] = 32'h3030;
    disp(12, 30, 1'b1, 32'hC1);
    issue_ready = 1'b1;
    q.push_back('{tag: 6'd10, v1: 32'h3030});
    q.push_back('{tag: 6'd12, v1: 32'hC1});
    tick();
    wakeup = '0; dispatch_valid = 1'b0;
    check("t4_older_first", 64'(issue_insn.insn_tag), 64'd10);
    drain(5);

    // Flush with five pending entries and a concurrent dispatch
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(41 + i, 40, 1'b0, 32'h0);
      tick();
    end
    check("t6_pre_count", 64'(free_count), 64'd3);
    flush = 1'b1; issue_ready = 1'b1;
    disp(50, 0, 1'b1, 32'h50);
    tick();
    flush = 1'b0; dispatch_valid = 1'b0;
    check("t6_free_count", 64'(free_count), 64'd8);
    check("t6_issue_valid", 64'(issue_valid), 64'd0);
    check("t6_issue_insn", 64'(|issue_insn), 64'd0);
    check("t6_is_full", 64'(is_full), 64'd0);
    check("t6_dispatch_ready", 64'(dispatch_ready), 64'd1);
    wakeup = 4'b0001; wakeup_tag[0] = 6'd40; wakeup_value[0] = 32'h40;
    tick();
    wakeup = '0;
    tick(); tick();
    check("t6_nothing_issues", 64'(issue_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
